block_slide_ctrl: RTL and testbench

Sequencer for the sliding block in the stacking game. After `start` it draws the current block into the VGA adapter pixel by pixel, holds it for a fixed number of video frames, erases it, steps it one pixel horizontally with bounce at the screen edges, and repeats. The loop ends when the player presses drop, leaving the block drawn and reporting its final x position. It sits between the game-level FSM (`start`/`drop`/`done`) and the VGA adapter pixel write port (`x_out`/`y_out`/`colour_out`/`plot`), and does its own frame counting from a one-cycle `frame_tick`.

---
 rtl/block_slide_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_block_slide_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/block_slide_ctrl.sv
// Sliding-block sequencer: draws a block, holds it for FRAMES frames, erases it,
// steps it one pixel with edge bounce, and repeats until the player drops it.
module block_slide_ctrl #(
  parameter int X_MAX  = 160,
  parameter int BLK_W  = 16,
  parameter int BLK_H  = 4,
  parameter int FRAMES = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       drop,
  input  logic       frame_tick,
  input  logic [6:0] y_in,
  input  logic [2:0] colour_in,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       plot,
  output logic       busy,
  output logic       done,
  output logic [7:0] pos_x
);

  localparam int PXW = (BLK_W > 1) ? $clog2(BLK_W) : 1;
  localparam int PYW = (BLK_H > 1) ? $clog2(BLK_H) : 1;
  localparam int FCW = $clog2(FRAMES + 1);

  localparam logic [7:0]     X_LAST  = 8'(X_MAX - BLK_W);
  localparam logic [PXW-1:0] PX_LAST = PXW'(BLK_W - 1);
  localparam logic [PYW-1:0] PY_LAST = PYW'(BLK_H - 1);
  localparam logic [FCW-1:0] FC_LAST = FCW'(FRAMES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DRAW, S_WAIT, S_ERASE, S_MOVE, S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     pos_x_q, pos_x_d;
  logic           dir_q, dir_d;          // 0 = moving right, 1 = moving left
  logic [PXW-1:0] px_q, px_d;
  logic [PYW-1:0] py_q, py_d;
  logic [FCW-1:0] fc_q, fc_d;
  logic           drop_req_q, drop_req_d;
  logic [6:0]     y_lat_q, y_lat_d;
  logic [2:0]     colour_lat_q, colour_lat_d;

  logic [7:0]     x_out_q;
  logic [6:0]     y_out_q;
  logic [2:0]     colour_out_q;
  logic           plot_q, busy_q, done_q;

  logic           last_pix;
  logic [PXW-1:0] px_scan;
  logic [PYW-1:0] py_scan;

  // Raster scan over the block footprint, x fastest, wrapping to 0,0 after the last pixel.
  always_comb begin
    last_pix = (px_q == PX_LAST) && (py_q == PY_LAST);
    px_scan  = px_q + PXW'(1);
    py_scan  = py_q;
    if (px_q == PX_LAST) begin
      px_scan = '0;
      py_scan = last_pix ? '0 : py_q + PYW'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    pos_x_d      = pos_x_q;
    dir_d        = dir_q;
    px_d         = px_q;
    py_d         = py_q;
    fc_d         = fc_q;
    y_lat_d      = y_lat_q;
    colour_lat_d = colour_lat_q;
    drop_req_d   = drop_req_q | ((state_q != S_IDLE) & drop);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          y_lat_d      = y_in;
          colour_lat_d = colour_in;
          pos_x_d      = '0;
          dir_d        = 1'b0;
          drop_req_d   = 1'b0;
          px_d         = '0;
          py_d         = '0;
          state_d      = S_DRAW;
        end
      end
      S_DRAW: begin
        px_d = px_scan;
        py_d = py_scan;
        if (last_pix) begin
          fc_d    = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (frame_tick) begin
          if (fc_q == FC_LAST) begin
            fc_d    = '0;
            // a drop arriving on the final tick still ends the loop
            state_d = (drop_req_q || drop) ? S_DONE : S_ERASE;
          end else begin
            fc_d = fc_q + FCW'(1);
          end
        end
      end
      S_ERASE: begin
        px_d = px_scan;
        py_d = py_scan;
        if (last_pix) state_d = S_MOVE;
      end
      S_MOVE: begin
        if (!dir_q) begin
          if (pos_x_q == X_LAST) begin
            dir_d   = 1'b1;
            pos_x_d = pos_x_q - 8'd1;
          end else begin
            pos_x_d = pos_x_q + 8'd1;
          end
        end else begin
          if (pos_x_q == 8'd0) begin
            dir_d   = 1'b0;
            pos_x_d = pos_x_q + 8'd1;
          end else begin
            pos_x_d = pos_x_q - 8'd1;
          end
        end
        state_d = S_DRAW;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from next-state so the first pixel lands the cycle after start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pos_x_q      <= '0;
      dir_q        <= 1'b0;
      px_q         <= '0;
      py_q         <= '0;
      fc_q         <= '0;
      drop_req_q   <= 1'b0;
      y_lat_q      <= '0;
      colour_lat_q <= '0;
      x_out_q      <= '0;
      y_out_q      <= '0;
      colour_out_q <= '0;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_x_q      <= pos_x_d;
      dir_q        <= dir_d;
      px_q         <= px_d;
      py_q         <= py_d;
      fc_q         <= fc_d;
      drop_req_q   <= drop_req_d;
      y_lat_q      <= y_lat_d;
      colour_lat_q <= colour_lat_d;
      x_out_q      <= pos_x_d + 8'(px_d);
      y_out_q      <= y_lat_d + 7'(py_d);
      colour_out_q <= (state_d == S_DRAW) ? colour_lat_d : 3'd0;
      plot_q       <= (state_d == S_DRAW) || (state_d == S_ERASE);
      busy_q       <= (state_d != S_IDLE);
      done_q       <= (state_d == S_DONE);
    end
  end

  assign x_out      = x_out_q;
  assign y_out      = y_out_q;
  assign colour_out = colour_out_q;
  assign plot       = plot_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pos_x      = pos_x_q;

endmodule

// File: tb/tb_block_slide_ctrl.sv
// Directed bench for block_slide_ctrl with a 16-wide screen, 4x2 block, 3-frame hold.
module tb_block_slide_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, drop, frame_tick;
  logic [6:0] y_in;
  logic [2:0] colour_in;
  logic [7:0] x_out, pos_x;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       plot, busy, done;

  int n_chk = 0;
  int n_err = 0;

  // left x of the block on each successive step: climb to 12, bounce, down to 0, bounce to 1
  localparam int NSTEP = 26;
  localparam int POS [NSTEP] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12,
                                 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1};

  block_slide_ctrl #(.X_MAX(16), .BLK_W(4), .BLK_H(2), .FRAMES(3)) dut (
    .clk(clk), .reset(reset), .start(start), .drop(drop), .frame_tick(frame_tick),
    .y_in(y_in), .colour_in(colour_in), .x_out(x_out), .y_out(y_out),
    .colour_out(colour_out), .plot(plot), .busy(busy), .done(done), .pos_x(pos_x)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Check n consecutive plot cycles of the block at (xb,yb); optional stray pulses mid-scan.
  task automatic pix(input int xb, input int yb, input int col, input int n,
                     input bit tk, input bit dr, input bit st);
    for (int i = 0; i < n; i++) begin
      chk("plot",   32'(plot), 32'd1);
      chk("x_out",  32'(x_out), 32'(xb + i % 4));
      chk("y_out",  32'(y_out), 32'(yb + i / 4));
      chk("colour", 32'(colour_out), 32'(col));
      chk("pos_x",  32'(pos_x), 32'(xb));
      frame_tick = tk && (i == 2);
      drop       = dr && (i == 3);
      start      = st && (i == 4);
      if (st && i == 4) begin
        y_in      = 7'd40;
        colour_in = 3'd6;
      end
      @(negedge clk);
    end
    frame_tick = 1'b0;
    drop       = 1'b0;
    start      = 1'b0;
  endtask

  // Hold: plot must stay low and busy high until the third tick is sampled.
  task automatic waitf();
    for (int t = 0; t < 3; t++) begin
      for (int c = 0; c < 2; c++) begin
        chk("wait_plot", 32'(plot), 32'd0);
        chk("wait_busy", 32'(busy), 32'd1);
        @(negedge clk);
      end
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end
  endtask

  task automatic move_cycle();
    chk("move_plot", 32'(plot), 32'd0);
    chk("move_busy", 32'(busy), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; drop = 1'b0; frame_tick = 1'b0;
    y_in = '0; colour_in = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_plot", 32'(plot), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_posx", 32'(pos_x), 32'd0);
    chk("rst_col",  32'(colour_out), 32'd0);
    chk("rst_x",    32'(x_out), 32'd0);
    chk("rst_y",    32'(y_out), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // start, then full slide across, bounce, back, bounce, drop at x=1
    start = 1'b1; y_in = 7'd10; colour_in = 3'd5;
    @(negedge clk);
    start = 1'b0; y_in = '0; colour_in = '0;
    for (int s = 0; s < NSTEP; s++) begin
      pix(POS[s], 10, 5, 8, s == 1, s == NSTEP - 1, 1'b0);
      waitf();
      if (s == NSTEP - 1) begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_plot",  32'(plot), 32'd0);
        chk("done_posx",  32'(pos_x), 32'd1);
        chk("done_busy",  32'(busy), 32'd1);
        @(negedge clk);
        chk("post_done",  32'(done), 32'd0);
        chk("post_busy",  32'(busy), 32'd0);
        chk("post_posx",  32'(pos_x), 32'd1);
        chk("post_plot",  32'(plot), 32'd0);
      end else begin
        pix(POS[s], 10, 0, 8, s == 0, 1'b0, 1'b0);
        move_cycle();
      end
    end

    // restart with new y/colour; start pulses while busy must not relatch
    start = 1'b1; y_in = 7'd20; colour_in = 3'd3;
    @(negedge clk);
    start = 1'b0;
    pix(0, 20, 3, 8, 1'b0, 1'b0, 1'b1);
    waitf();
    pix(0, 20, 0, 8, 1'b0, 1'b0, 1'b1);
    move_cycle();
    pix(1, 20, 3, 8, 1'b0, 1'b0, 1'b0);
    waitf();

    // reset part-way through ERASE
    pix(1, 20, 0, 4, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_plot", 32'(plot), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_posx", 32'(pos_x), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_idle", 32'(busy), 32'd0);

    // start with simultaneous drop: start wins, drop_req cleared, so the loop continues
    start = 1'b1; drop = 1'b1; y_in = 7'd10; colour_in = 3'd5;
    @(negedge clk);
    start = 1'b0; drop = 1'b0;
    pix(0, 10, 5, 8, 1'b0, 1'b0, 1'b0);
    waitf();
    pix(0, 10, 0, 8, 1'b0, 1'b0, 1'b0);
    move_cycle();
    chk("resume_posx", 32'(pos_x), 32'd1);
    chk("resume_plot", 32'(plot), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
